dmem_arbiter: RTL

Single-port data-memory arbiter and sequencer for the pipelined CPU. It shares the byte-addressed, little-endian data memory between two requesters: the MEM-stage port of the pipeline and a debug/loader port used by benches to preload and inspect memory. It sequences each access over MEM_LAT cycles, stalls the pipeline while the CPU's access is pending, and counts stall cycles for the stall/flush statistics.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU MEM-stage port, debug/loader port,
// memory-side port and status. Signal suffixes are from the arbiter's point of view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_stall_o;

  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [31:0]       dbg_addr_i;
  logic [31:0]       dbg_wdata_i;
  logic [31:0]       dbg_rdata_o;
  logic              dbg_ack_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  logic              busy_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_rdata_o, dbg_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output busy_o, stall_cnt_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_rdata_o, dbg_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  busy_o, stall_cnt_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: round-robin between the CPU MEM stage and the
// debug port, MEM_LAT-cycle access sequencing, CPU stall generation and stall counting.
module dmem_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:2]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d;
  logic [31:0]         dbg_rdata_q, dbg_rdata_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                grant_dbg;
  logic                cpu_stall;
  logic                in_access;
  logic                unused_addr_bits;

  // Byte-lane and out-of-range address bits are deliberately dropped (wrap modulo 2^ADDR_W).
  assign unused_addr_bits = ^{bus.cpu_addr_i[31:ADDR_W], bus.cpu_addr_i[1:0],
                              bus.dbg_addr_i[31:ADDR_W], bus.dbg_addr_i[1:0]};

  // On a conflict the requester not served last wins; a lone requester always wins.
  assign grant_dbg = bus.dbg_req_i && (!bus.cpu_req_i || last_q == OWN_CPU);
  assign in_access = (state_q == S_ACCESS);
  assign cpu_stall = rst_i && bus.cpu_req_i && !(state_q == S_DONE && owner_q == OWN_CPU);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req_i || bus.dbg_req_i) begin
          owner_d = grant_dbg ? OWN_DBG : OWN_CPU;
          we_d    = grant_dbg ? bus.dbg_we_i : bus.cpu_we_i;
          addr_d  = grant_dbg ? bus.dbg_addr_i[ADDR_W-1:2] : bus.cpu_addr_i[ADDR_W-1:2];
          wdata_d = grant_dbg ? bus.dbg_wdata_i : bus.cpu_wdata_i;
          lat_d   = LAT_W'(MEM_LAT - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (lat_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_d = bus.mem_rdata_i;
            else                    dbg_rdata_d = bus.mem_rdata_i;
          end
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_cnt_d = (cpu_stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.mem_en_o    = in_access;
  assign bus.mem_we_o    = in_access && we_q;
  assign bus.mem_addr_o  = in_access ? {addr_q, 2'b00} : '0;
  assign bus.mem_wdata_o = in_access ? wdata_q : '0;
  assign bus.cpu_rdata_o = cpu_rdata_q;
  assign bus.cpu_stall_o = cpu_stall;
  assign bus.dbg_rdata_o = dbg_rdata_q;
  assign bus.dbg_ack_o   = (state_q == S_DONE) && (owner_q == OWN_DBG);
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.stall_cnt_o = stall_cnt_q;
endmodule
